// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite row fetcher.
//   fetch_state_t    : fetcher FSM encoding
//   SPR_COL_BITS     : column index width for the default sprite width
//   SPR_ROW_BITS     : row index width for the default sprite height
//   TRANSPARENT_DEF  : default colour key (magenta), treated as no-hit
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    READY
  } fetch_state_t;

  localparam int unsigned SPRITE_W_DEF = 32;
  localparam int unsigned SPRITE_H_DEF = 32;
  localparam int unsigned SPR_COL_BITS = $clog2(SPRITE_W_DEF);
  localparam int unsigned SPR_ROW_BITS = $clog2(SPRITE_H_DEF);

  localparam logic [23:0] TRANSPARENT_DEF = 24'hFF00FF;

endpackage

// File: rtl/sprite_line_buffer.sv
// One-row pixel buffer for a single sprite.
//   clk   : write clock
//   we    : write enable
//   waddr : write column
//   wdata : pixel to store
//   raddr : read column (combinational read)
//   rdata : stored pixel at raddr
module sprite_line_buffer #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset; row_valid gates their use.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_row_fetcher.sv
// Sprite row fetcher: during hblank copies one sprite row from the pixel ROM
// into a local line buffer, then during active video returns the buffered
// pixel and a hit flag for the current column.
//   clk, rst               : clock, synchronous active-high reset
//   line_start, next_y     : hblank start pulse and upcoming scanline
//   sprite_x, sprite_y     : sprite position, sampled on line_start
//   rom_addr, rom_data     : registered ROM address, combinational ROM pixel
//   pix_valid, pix_x       : active-video qualifier and current column
//   pix_color, pix_hit     : registered sprite pixel and opaque-hit flag
//   busy                   : high while a row fetch is in progress
module sprite_row_fetcher
  import sprite_pkg::*;
#(
  parameter int unsigned ADDRESS     = 10,
  parameter int unsigned COLOR_BITS  = 24,
  parameter int unsigned SPRITE_W    = 32,
  parameter int unsigned SPRITE_H    = 32,
  parameter int unsigned H_BITS      = 10,
  parameter int unsigned V_BITS      = 10,
  parameter logic [23:0] TRANSPARENT = TRANSPARENT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_start,
  input  logic [V_BITS-1:0]     next_y,
  input  logic [H_BITS-1:0]     sprite_x,
  input  logic [V_BITS-1:0]     sprite_y,
  output logic [ADDRESS-1:0]    rom_addr,
  input  logic [COLOR_BITS-1:0] rom_data,
  input  logic                  pix_valid,
  input  logic [H_BITS-1:0]     pix_x,
  output logic [COLOR_BITS-1:0] pix_color,
  output logic                  pix_hit,
  output logic                  busy
);

  localparam int unsigned COL_BITS = $clog2(SPRITE_W);
  localparam int unsigned ROW_BITS = $clog2(SPRITE_H);
  localparam logic [COLOR_BITS-1:0] KEY = COLOR_BITS'(TRANSPARENT);
  localparam logic [COL_BITS-1:0]   LAST_COL = COL_BITS'(SPRITE_W - 1);

  fetch_state_t state, state_next;

  logic [H_BITS-1:0]     sx;
  logic [ROW_BITS-1:0]   row_lo;
  logic [COL_BITS-1:0]   col;
  logic [COL_BITS-1:0]   col_d;
  logic                  issuing;
  logic                  we_d;
  logic                  row_valid;

  logic [V_BITS:0]       row_c;
  logic                  row_in_range_c;
  logic [H_BITS:0]       dx_c;
  logic                  dx_in_range_c;
  logic [COLOR_BITS-1:0] buf_rdata;
  logic                  hit_c;

  // Signed row offset; the extra bit keeps sprite_y > next_y from wrapping.
  assign row_c          = {1'b0, next_y} - {1'b0, sprite_y};
  assign row_in_range_c = !row_c[V_BITS] && (row_c[V_BITS-1:0] < V_BITS'(SPRITE_H));

  // Signed column offset; negative or >= width means outside the sprite.
  assign dx_c          = {1'b0, pix_x} - {1'b0, sx};
  assign dx_in_range_c = !dx_c[H_BITS] && (dx_c[H_BITS-1:0] < H_BITS'(SPRITE_W));

  assign hit_c = pix_valid && row_valid && (state == READY) && dx_in_range_c
                 && (buf_rdata != KEY);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: line_start restarts from any state; FETCH ends once the
  // last address has been issued and its delayed write has drained.
  always_comb begin
    state_next = state;
    if (line_start) begin
      state_next = row_in_range_c ? FETCH : READY;
    end else begin
      case (state)
        FETCH: begin
          if (!issuing && !we_d) begin
            state_next = READY;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Fetch datapath: address issue, delayed write index, row_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx        <= '0;
      row_lo    <= '0;
      col       <= '0;
      col_d     <= '0;
      issuing   <= 1'b0;
      we_d      <= 1'b0;
      row_valid <= 1'b0;
      rom_addr  <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_next == FETCH);
      we_d <= 1'b0;
      if (line_start) begin
        sx        <= sprite_x;
        row_lo    <= row_c[ROW_BITS-1:0];
        col       <= '0;
        issuing   <= row_in_range_c;
        row_valid <= 1'b0;
      end else if (state == FETCH) begin
        if (issuing) begin
          rom_addr <= ADDRESS'({row_lo, col});
          we_d     <= 1'b1;
          col_d    <= col;
          if (col == LAST_COL) begin
            issuing <= 1'b0;
          end else begin
            col <= col + COL_BITS'(1);
          end
        end else if (!we_d) begin
          row_valid <= 1'b1;
        end
      end
    end
  end

  // ROM data is written one cycle after its address was registered.
  sprite_line_buffer #(
    .DEPTH (SPRITE_W),
    .WIDTH (COLOR_BITS)
  ) u_line_buffer (
    .clk   (clk),
    .we    (we_d),
    .waddr (col_d),
    .wdata (rom_data),
    .raddr (dx_c[COL_BITS-1:0]),
    .rdata (buf_rdata)
  );

  // Registered pixel output.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_hit   <= 1'b0;
      pix_color <= '0;
    end else begin
      pix_hit   <= hit_c;
      pix_color <= hit_c ? buf_rdata : '0;
    end
  end

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Directed bench for sprite_row_fetcher with a behavioural pixel ROM
// (mem[a] = a, colour key planted at row 5, column 3).
module tb_sprite_row_fetcher;

  logic        clk;
  logic        rst;
  logic        line_start;
  logic [9:0]  next_y;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic [9:0]  rom_addr;
  logic [23:0] rom_data;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [23:0] pix_color;
  logic        pix_hit;
  logic        busy;

  int checks;
  int failures;

  logic [23:0] rom [1024];

  sprite_row_fetcher dut (
    .clk        (clk),
    .rst        (rst),
    .line_start (line_start),
    .next_y     (next_y),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_color  (pix_color),
    .pix_hit    (pix_hit),
    .busy       (busy)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input int ny, input int sxv, input int syv);
    next_y     = 10'(ny);
    sprite_x   = 10'(sxv);
    sprite_y   = 10'(syv);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // Sweep pix_x and compare against the expected sprite row contents.
  task automatic sweep(input int lo, input int hi, input int sxv, input bit row_ok, input int row);
    int dx;
    bit exp_hit;
    int exp_col;
    for (int x = lo; x <= hi; x++) begin
      pix_x     = 10'(x);
      pix_valid = 1'b1;
      tick();
      dx      = x - sxv;
      exp_hit = row_ok && (dx >= 0) && (dx < 32) && !(row == 5 && dx == 3);
      exp_col = exp_hit ? (row * 32 + dx) : 0;
      check($sformatf("hit x=%0d", x), 32'(pix_hit), 32'(exp_hit));
      check($sformatf("color x=%0d", x), 32'(pix_color), 32'(exp_col));
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    for (int a = 0; a < 1024; a++) rom[a] = 24'(a);
    rom[5*32+3] = 24'hFF00FF;

    rst        = 1'b1;
    line_start = 1'b0;
    next_y     = '0;
    sprite_x   = '0;
    sprite_y   = '0;
    pix_valid  = 1'b0;
    pix_x      = '0;

    // 1: reset
    tick();
    tick();
    check("rst pix_hit", 32'(pix_hit), 32'd0);
    check("rst pix_color", 32'(pix_color), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst rom_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    sweep(0, 40, 0, 1'b0, 0);

    // 2: fetch row 5, addresses 160..191
    start_line(105, 200, 100);
    check("fetch busy start", 32'(busy), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      check($sformatf("fetch rom_addr k=%0d", k), 32'(rom_addr), 32'(160 + k - 1));
      check($sformatf("fetch busy k=%0d", k), 32'(busy), 32'd1);
    end
    tick();
    tick();
    check("fetch ready busy", 32'(busy), 32'd0);
    check("fetch rom_addr hold", 32'(rom_addr), 32'd191);

    // 3: display with transparent column 3
    sweep(190, 240, 200, 1'b1, 5);

    // 4: vertical clipping above and below
    start_line(99, 200, 100);
    check("clip top busy", 32'(busy), 32'd0);
    sweep(190, 240, 200, 1'b0, 0);
    start_line(132, 200, 100);
    check("clip bottom busy", 32'(busy), 32'd0);
    sweep(190, 240, 200, 1'b0, 0);

    // 4: right-edge clipping, no wrap to the left
    start_line(106, 1020, 100);
    repeat (34) tick();
    check("clip right busy", 32'(busy), 32'd0);
    sweep(1010, 1023, 1020, 1'b1, 6);
    sweep(0, 27, 1020, 1'b1, 6);

    // 5: abort mid-fetch and restart on row 6
    start_line(105, 200, 100);
    repeat (10) tick();
    start_line(106, 200, 100);
    for (int k = 1; k <= 32; k++) begin
      tick();
      check($sformatf("abort rom_addr k=%0d", k), 32'(rom_addr), 32'(192 + k - 1));
    end
    tick();
    tick();
    check("abort ready busy", 32'(busy), 32'd0);
    sweep(190, 240, 200, 1'b1, 6);

    // 6: reset during fetch
    start_line(105, 200, 100);
    repeat (15) tick();
    check("mid busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst mid busy", 32'(busy), 32'd0);
    check("rst mid rom_addr", 32'(rom_addr), 32'd0);
    check("rst mid pix_hit", 32'(pix_hit), 32'd0);
    repeat (40) tick();
    check("rst idle busy", 32'(busy), 32'd0);
    sweep(190, 240, 200, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
